// File: rtl/ct_spsram_arb_1024x32.sv
// ct_spsram_arb_1024x32
// Round-robin arbiter/sequencer sharing one 1024x32 single-port SRAM macro
// between two valid/ready requesters. It turns byte enables into the macro's
// active-low CEN/GWEN/WEN controls. One cycle later it routes the read data
// back to the port that issued the read.
// Optional feature: define SPSRAM_INIT_EN to clear the whole array to zero
// after reset before any request is accepted.
module ct_spsram_arb_1024x32 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  a_req_vld,
  output logic                  a_req_rdy,
  input  logic                  a_req_wr,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  input  logic [BE_WIDTH-1:0]   a_req_be,
  output logic                  a_rsp_vld,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  input  logic                  b_req_vld,
  output logic                  b_req_rdy,
  input  logic                  b_req_wr,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  input  logic [BE_WIDTH-1:0]   b_req_be,
  output logic                  b_rsp_vld,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  init_done
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Byte enables (active-high) to the macro's active-low per-bit write mask
  function automatic logic [DATA_WIDTH-1:0] be_to_wen(input logic [BE_WIDTH-1:0] be);
    logic [DATA_WIDTH-1:0] wen;
    wen = '1;
    for (int i = 0; i < BE_WIDTH; i++) begin
      wen[8*i +: 8] = {8{~be[i]}};
    end
    return wen;
  endfunction

  logic                  rr_ptr;
  logic                  accept_en;
  logic                  grant_a_p0;
  logic                  grant_b_p0;
  logic                  grant_p0;
  logic                  sel_wr_p0;
  logic [ADDR_WIDTH-1:0] sel_addr_p0;
  logic [DATA_WIDTH-1:0] sel_wdata_p0;
  logic [BE_WIDTH-1:0]   sel_be_p0;
  logic                  rsp_vld_p1;
  logic                  rsp_port_p1;
  logic [ADDR_WIDTH-1:0] hold_a_p1;
  logic [DATA_WIDTH-1:0] hold_d_p1;
  logic                  clr_act;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef SPSRAM_INIT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_state;

  // Init FSM state register; reset restarts the clear sequence
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Clear address counter; wraps back to 0 on the last clear write
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b)              clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  end

  // Init FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Init FSM outputs
  always_comb begin
    init_done = 1'b0;
    clr_state = 1'b0;
    case (state)
      ST_CLEAR: clr_state = 1'b1;
      ST_DONE:  init_done = 1'b1;
      default:  ;
    endcase
  end

  assign clr_act  = clr_state & cpurst_b;
  assign clr_addr = clr_cnt;
`else
  logic init_q;

  // Without clearing, the SRAM is usable from the first cycle after reset
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) init_q <= 1'b0;
    else           init_q <= 1'b1;
  end

  assign init_done = init_q;
  assign clr_act   = 1'b0;
  assign clr_addr  = '0;
`endif

  // ---- stage p0: arbitration and SRAM command drive ----
  assign accept_en  = cpurst_b & init_done;
  assign grant_a_p0 = accept_en & a_req_vld & (~b_req_vld | (rr_ptr == PORT_A));
  assign grant_b_p0 = accept_en & b_req_vld & (~a_req_vld | (rr_ptr == PORT_B));
  assign grant_p0   = grant_a_p0 | grant_b_p0;
  assign a_req_rdy  = grant_a_p0;
  assign b_req_rdy  = grant_b_p0;

  assign sel_wr_p0    = grant_a_p0 ? a_req_wr    : b_req_wr;
  assign sel_addr_p0  = grant_a_p0 ? a_req_addr  : b_req_addr;
  assign sel_wdata_p0 = grant_a_p0 ? a_req_wdata : b_req_wdata;
  assign sel_be_p0    = grant_a_p0 ? a_req_be    : b_req_be;

  // Round-robin pointer hands priority to the other port after every grant
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b)       rr_ptr <= PORT_A;
    else if (grant_a_p0) rr_ptr <= PORT_B;
    else if (grant_b_p0) rr_ptr <= PORT_A;
  end

  // SRAM pins: clear write, granted command, or idle with address/data held
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = hold_a_p1;
    sram_d    = hold_d_p1;
    if (clr_act) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = clr_addr;
      sram_d    = '0;
    end else if (grant_p0) begin
      sram_cen = 1'b0;
      sram_a   = sel_addr_p0;
      sram_d   = sel_wdata_p0;
      // A write with no byte enabled degrades to a harmless read-type access
      if (sel_wr_p0 && (|sel_be_p0)) begin
        sram_gwen = 1'b0;
        sram_wen  = be_to_wen(sel_be_p0);
      end
    end
  end

  // ---- stage p1: read tag and held SRAM address/data ----
  // Held address/data keep the macro inputs stable while no access is granted
  always_ff @(posedge forever_cpuclk) begin
    hold_a_p1 <= sram_a;
    hold_d_p1 <= sram_d;
  end

  // Read tag {vld,port}; only reads (write flag low) produce a response
  always_ff @(posedge forever_cpuclk) begin
    rsp_port_p1 <= grant_b_p0;
    if (!cpurst_b) rsp_vld_p1 <= 1'b0;
    else           rsp_vld_p1 <= grant_p0 & ~sel_wr_p0;
  end

  // Masked with reset so a read caught by reset never shows a response
  assign a_rsp_vld  = cpurst_b & rsp_vld_p1 & (rsp_port_p1 == PORT_A);
  assign b_rsp_vld  = cpurst_b & rsp_vld_p1 & (rsp_port_p1 == PORT_B);
  assign a_rsp_data = sram_q;
  assign b_rsp_data = sram_q;

endmodule

// File: tb/tb_ct_spsram_arb_1024x32.sv
// Testbench for ct_spsram_arb_1024x32: table-driven vectors with a response
// scoreboard, plus hand-written reset and arbitration sequences.
module tb_ct_spsram_arb_1024x32;

  logic        clk;
  logic        cpurst_b;
  logic        a_req_vld, a_req_rdy, a_req_wr, a_rsp_vld;
  logic [9:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_rsp_data;
  logic [3:0]  a_req_be;
  logic        b_req_vld, b_req_rdy, b_req_wr, b_rsp_vld;
  logic [9:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_data;
  logic [3:0]  b_req_be;
  logic [9:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [31:0] sram_wen, sram_d, sram_q;
  logic        init_done;

  ct_spsram_arb_1024x32 dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b),
    .a_req_vld(a_req_vld), .a_req_rdy(a_req_rdy), .a_req_wr(a_req_wr),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_be(a_req_be),
    .a_rsp_vld(a_rsp_vld), .a_rsp_data(a_rsp_data),
    .b_req_vld(b_req_vld), .b_req_rdy(b_req_rdy), .b_req_wr(b_req_wr),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_be(b_req_be),
    .b_rsp_vld(b_rsp_vld), .b_rsp_data(b_rsp_data),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with active-low controls and 1-cycle read
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  typedef struct {
    logic        a_vld, a_wr;
    logic [9:0]  a_addr;
    logic [31:0] a_wd;
    logic [3:0]  a_be;
    logic        b_vld, b_wr;
    logic [9:0]  b_addr;
    logic [31:0] b_wd;
    logic [3:0]  b_be;
    logic        exp_a_rdy, exp_b_rdy, exp_gwen;
    logic [31:0] exp_wen;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rsp_t;

`ifdef SPSRAM_INIT_EN
  localparam int EXP_INIT_N = 1025;
  localparam int EXP_CLR_N  = 1024;
`else
  localparam int EXP_INIT_N = 1;
  localparam int EXP_CLR_N  = 0;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  rsp_t        exp_q[$];
  vec_t        tbl[$];
  logic [31:0] ref_mem [1024];
  logic [9:0]  last_a;
  logic [31:0] last_d;
  logic        last_ok = 1'b0;
  logic        mon_en = 1'b0;
  int          spur = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic aw, input logic [9:0] aa,
                              input logic [31:0] ad, input logic [3:0] abe,
                              input logic bv, input logic bw, input logic [9:0] ba,
                              input logic [31:0] bd, input logic [3:0] bbe,
                              input logic ea, input logic eb, input logic eg,
                              input logic [31:0] ew);
    vec_t v;
    v.a_vld = av; v.a_wr = aw; v.a_addr = aa; v.a_wd = ad; v.a_be = abe;
    v.b_vld = bv; v.b_wr = bw; v.b_addr = ba; v.b_wd = bd; v.b_be = bbe;
    v.exp_a_rdy = ea; v.exp_b_rdy = eb; v.exp_gwen = eg; v.exp_wen = ew;
    return v;
  endfunction

  // Catches any response that leaks out of a read dropped by reset
  always @(negedge clk) begin
    if (mon_en && (a_rsp_vld === 1'b1 || b_rsp_vld === 1'b1)) spur <= spur + 1;
  end

  // One cycle: drive, check at negedge (response of previous cycle + this grant)
  task automatic apply_vec(input vec_t v);
    rsp_t        e;
    logic        gnt, wr;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    a_req_vld = v.a_vld; a_req_wr = v.a_wr; a_req_addr = v.a_addr;
    a_req_wdata = v.a_wd; a_req_be = v.a_be;
    b_req_vld = v.b_vld; b_req_wr = v.b_wr; b_req_addr = v.b_addr;
    b_req_wdata = v.b_wd; b_req_be = v.b_be;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk1("a_rsp_vld", a_rsp_vld, e.port == 1'b0);
      chk1("b_rsp_vld", b_rsp_vld, e.port == 1'b1);
      if (e.port == 1'b0) chk32("a_rsp_data", a_rsp_data, e.data);
      else                chk32("b_rsp_data", b_rsp_data, e.data);
    end else begin
      chk1("a_rsp_vld_idle", a_rsp_vld, 1'b0);
      chk1("b_rsp_vld_idle", b_rsp_vld, 1'b0);
    end
    chk1("a_req_rdy", a_req_rdy, v.exp_a_rdy);
    chk1("b_req_rdy", b_req_rdy, v.exp_b_rdy);
    gnt = v.exp_a_rdy | v.exp_b_rdy;
    chk1("sram_cen", sram_cen, ~gnt);
    chk1("sram_gwen", sram_gwen, gnt ? v.exp_gwen : 1'b1);
    chk32("sram_wen", sram_wen, gnt ? v.exp_wen : 32'hFFFF_FFFF);
    if (gnt) begin
      wr   = v.exp_a_rdy ? v.a_wr   : v.b_wr;
      addr = v.exp_a_rdy ? v.a_addr : v.b_addr;
      wd   = v.exp_a_rdy ? v.a_wd   : v.b_wd;
      be   = v.exp_a_rdy ? v.a_be   : v.b_be;
      chk32("sram_a", 32'(sram_a), 32'(addr));
      chk32("sram_d", sram_d, wd);
      last_a = addr; last_d = wd; last_ok = 1'b1;
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
      end else begin
        e.port = v.exp_b_rdy;
        e.data = ref_mem[addr];
        exp_q.push_back(e);
      end
    end else if (last_ok) begin
      chk32("sram_a_hold", 32'(sram_a), 32'(last_a));
      chk32("sram_d_hold", sram_d, last_d);
    end
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for init_done after reset release; rdy must stay low
  task automatic wait_init();
    int n, clr_n, bad;
    n = 0; clr_n = 0; bad = 0;
    a_req_vld = 1'b1; a_req_wr = 1'b0; b_req_vld = 1'b1; b_req_wr = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) break;
      n++;
      if (a_req_rdy !== 1'b0 || b_req_rdy !== 1'b0) bad++;
      if (sram_cen === 1'b0 && sram_gwen === 1'b0 && sram_wen === 32'h0) clr_n++;
    end
    a_req_vld = 1'b0; b_req_vld = 1'b0;
    chk32("init_latency", n, EXP_INIT_N);
    chk32("init_rdy_low", bad, 0);
    chk32("clear_writes", clr_n, EXP_CLR_N);
`ifdef SPSRAM_INIT_EN
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
`endif
    last_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk(0,0,10'h0,32'h0,4'h0, 0,0,10'h0,32'h0,4'h0, 0,0,1,32'hFFFF_FFFF);

`ifdef SPSRAM_INIT_EN
    tbl.push_back(mk(1,0,10'h2A7,32'h0,4'h0, 0,0,10'h0,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
`endif
    // T1: write then read back on A
    tbl.push_back(mk(1,1,10'h005,32'hDEADBEEF,4'hF, 0,0,10'h0,32'h0,4'h0, 1,0,0,32'h0000_0000));
    tbl.push_back(mk(1,0,10'h005,32'h0,4'h0,        0,0,10'h0,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
    // T3: partial write with be=0101
    tbl.push_back(mk(1,1,10'h3FF,32'h11223344,4'hF, 0,0,10'h0,32'h0,4'h0, 1,0,0,32'h0000_0000));
    tbl.push_back(mk(1,1,10'h3FF,32'hAABBCCDD,4'h5, 0,0,10'h0,32'h0,4'h0, 1,0,0,32'hFF00_FF00));
    tbl.push_back(mk(1,0,10'h3FF,32'h0,4'h0,        0,0,10'h0,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
    // T6: B alone three times, then both valid -> A
    tbl.push_back(mk(0,0,10'h0,32'h0,4'h0, 1,1,10'h010,32'h0BADF00D,4'hF, 0,1,0,32'h0000_0000));
    tbl.push_back(mk(0,0,10'h0,32'h0,4'h0, 1,0,10'h010,32'h0,4'h0,        0,1,1,32'hFFFF_FFFF));
    tbl.push_back(mk(0,0,10'h0,32'h0,4'h0, 1,0,10'h005,32'h0,4'h0,        0,1,1,32'hFFFF_FFFF));
    tbl.push_back(mk(1,0,10'h3FF,32'h0,4'h0, 1,0,10'h005,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
    tbl.push_back(mk(1,0,10'h3FF,32'h0,4'h0, 1,0,10'h005,32'h0,4'h0, 0,1,1,32'hFFFF_FFFF));
    tbl.push_back(mk(1,0,10'h010,32'h0,4'h0, 1,0,10'h3FF,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
    tbl.push_back(mk(1,0,10'h010,32'h0,4'h0, 1,0,10'h3FF,32'h0,4'h0, 0,1,1,32'hFFFF_FFFF));
    // write with be=0 is a NOP access, then an idle cycle holding address/data
    tbl.push_back(mk(1,1,10'h020,32'h12345678,4'h0, 0,0,10'h0,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
    tbl.push_back(idle);
    // top byte written from B, both read back under arbitration
    tbl.push_back(mk(0,0,10'h0,32'h0,4'h0, 1,1,10'h3FF,32'hEE000000,4'h8, 0,1,0,32'h00FF_FFFF));
    tbl.push_back(mk(1,0,10'h3FF,32'h0,4'h0, 1,0,10'h005,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
    tbl.push_back(mk(1,0,10'h3FF,32'h0,4'h0, 1,0,10'h005,32'h0,4'h0, 0,1,1,32'hFFFF_FFFF));
    // write at N by A, read of same address at N+1 by B and N+2 by A
    tbl.push_back(mk(1,1,10'h005,32'hCAFEF00D,4'hF, 1,0,10'h005,32'h0,4'h0, 1,0,0,32'h0000_0000));
    tbl.push_back(mk(1,0,10'h005,32'h0,4'h0,        1,0,10'h005,32'h0,4'h0, 0,1,1,32'hFFFF_FFFF));
    tbl.push_back(mk(1,0,10'h005,32'h0,4'h0,        1,0,10'h005,32'h0,4'h0, 1,0,1,32'hFFFF_FFFF));
    tbl.push_back(idle);

    // Reset: both ports asking, nothing may be granted or driven
    cpurst_b = 1'b0;
    a_req_vld = 1'b1; a_req_wr = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    b_req_vld = 1'b1; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_a_rdy", a_req_rdy, 1'b0);
    chk1("rst_b_rdy", b_req_rdy, 1'b0);
    chk1("rst_cen", sram_cen, 1'b1);
    chk1("rst_gwen", sram_gwen, 1'b1);
    chk32("rst_wen", sram_wen, 32'hFFFF_FFFF);
    chk1("rst_a_rsp_vld", a_rsp_vld, 1'b0);
    chk1("rst_b_rsp_vld", b_rsp_vld, 1'b0);
    chk1("rst_init_done", init_done, 1'b0);
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    wait_init();

    foreach (tbl[i]) apply_vec(tbl[i]);

    // T4: B read, then reset the following cycle; the read must vanish
    a_req_vld = 1'b0;
    b_req_vld = 1'b1; b_req_wr = 1'b0; b_req_addr = 10'h010;
    @(negedge clk);
    chk1("t4_b_rdy", b_req_rdy, 1'b1);
    @(posedge clk); #1;
    cpurst_b = 1'b0; mon_en = 1'b1;
    a_req_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("t4_rst_a_rdy", a_req_rdy, 1'b0);
      chk1("t4_rst_b_rdy", b_req_rdy, 1'b0);
      chk1("t4_rst_cen", sram_cen, 1'b1);
    end
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    wait_init();
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk32("t4_no_rsp_after_reset", spur, 0);

    // T2: both valid continuously after reset -> A,B,A,B,A,B
    for (int i = 0; i < 6; i++) begin
      apply_vec(mk(1,0,10'h005,32'h0,4'h0, 1,0,10'h3FF,32'h0,4'h0,
                   (i % 2) == 0, (i % 2) == 1, 1, 32'hFFFF_FFFF));
    end
    apply_vec(idle);
    chk32("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
